// File: rtl/fetch_unit.sv
// fetch_unit: dual-issue instruction fetch stage.
// Issues one aligned 8-byte pair read per cycle to a synchronous instruction
// memory, buffers returned pairs in a 2-entry queue and hands them to IF/ID
// over valid/ready. Branch redirects flush all fetched-but-unconsumed work.
module fetch_unit #(
  parameter int PC_WIDTH        = 11,
  parameter int PAIR_ADDR_WIDTH = PC_WIDTH - 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fetch_enable,
  input  logic                       redirect,
  input  logic [PC_WIDTH-1:0]        redirect_pc,
  output logic                       imem_req,
  output logic [PAIR_ADDR_WIDTH-1:0] imem_addr,
  input  logic [63:0]                imem_rdata,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_instr1,
  output logic [31:0]                out_instr2,
  output logic [1:0]                 out_slot_mask,
  output logic [PC_WIDTH-1:0]        out_pc_plus8
);

  // The PC is kept as a pair index: bit 2 only matters for the first pair
  // after a redirect and lives in first_mask, bits [1:0] are always zero.
  logic [PAIR_ADDR_WIDTH-1:0] pc_pair;
  logic [1:0]                 first_mask;

  logic                       inf_valid;
  logic [PAIR_ADDR_WIDTH-1:0] inf_pair;
  logic [1:0]                 inf_mask;

  // Queue entry 0 is always the head, so the out_* ports come straight
  // from its registers.
  logic [31:0]         q_instr1 [2];
  logic [31:0]         q_instr2 [2];
  logic [1:0]          q_mask   [2];
  logic [PC_WIDTH-1:0] q_pcp8   [2];
  logic [1:0]          count;

  logic       pop;
  logic       push;
  logic       issue;
  logic       wr_idx;
  logic [2:0] occ;
  logic [1:0] count_nxt;
  logic [PC_WIDTH-1:0] inf_pcp8;

  // Byte offset bits of the redirect target carry no meaning for fetch.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Handshake, issue decision and queue write position.
  always_comb begin
    pop       = out_valid & out_ready;
    push      = inf_valid & ~redirect;
    occ       = {1'b0, count} + {2'b00, inf_valid};
    // Gated by reset so no request escapes while the block is held in reset.
    issue     = reset & fetch_enable & ~redirect & (occ < (3'd2 + {2'b00, pop}));
    // Tail slot after any same-cycle pop: 1 if count==2 (pop implied) or count==1 without pop.
    wr_idx    = (count == 2'd2) | ((count == 2'd1) & ~pop);
    count_nxt = count + {1'b0, push} - {1'b0, pop};
    inf_pcp8  = {inf_pair + 1'b1, 3'b000};
  end

  assign imem_req      = issue;
  assign imem_addr     = pc_pair;
  assign out_valid     = (count != 2'd0);
  assign out_instr1    = q_instr1[0];
  assign out_instr2    = q_instr2[0];
  assign out_slot_mask = q_mask[0];
  assign out_pc_plus8  = q_pcp8[0];

  // PC, first-pair mask and in-flight tag; redirect overrides everything.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_pair    <= '0;
      first_mask <= 2'b11;
      inf_valid  <= 1'b0;
      inf_pair   <= '0;
      inf_mask   <= 2'b00;
    end else if (redirect) begin
      pc_pair    <= redirect_pc[PC_WIDTH-1:3];
      first_mask <= redirect_pc[2] ? 2'b01 : 2'b11;
      inf_valid  <= 1'b0;
    end else if (issue) begin
      inf_valid  <= 1'b1;
      inf_pair   <= pc_pair;
      inf_mask   <= first_mask;
      pc_pair    <= pc_pair + 1'b1;
      first_mask <= 2'b11;
    end else begin
      inf_valid  <= 1'b0;
    end
  end

  // Two-entry queue: shift on pop, write returning pair at the tail.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        q_instr1[i] <= '0;
        q_instr2[i] <= '0;
        q_mask[i]   <= '0;
        q_pcp8[i]   <= '0;
      end
    end else if (redirect) begin
      count <= 2'd0;
    end else begin
      count <= count_nxt;
      if (pop) begin
        q_instr1[0] <= q_instr1[1];
        q_instr2[0] <= q_instr2[1];
        q_mask[0]   <= q_mask[1];
        q_pcp8[0]   <= q_pcp8[1];
      end
      if (push) begin
        q_instr1[wr_idx] <= imem_rdata[63:32];
        q_instr2[wr_idx] <= imem_rdata[31:0];
        q_mask[wr_idx]   <= inf_mask;
        q_pcp8[wr_idx]   <= inf_pcp8;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: fetch_unit against a stream-level reference model.
// The model keeps a list of expected pairs (base address, mask, cycle at which
// the pair may first be seen) and the next address the fetch stream should use.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        fetch_enable;
  logic        redirect;
  logic [10:0] redirect_pc;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [63:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr1;
  logic [31:0] out_instr2;
  logic [1:0]  out_slot_mask;
  logic [10:0] out_pc_plus8;

  fetch_unit dut (
    .clk          (clk),
    .reset        (reset),
    .fetch_enable (fetch_enable),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_instr1   (out_instr1),
    .out_instr2   (out_instr2),
    .out_slot_mask(out_slot_mask),
    .out_pc_plus8 (out_pc_plus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory whose 32-bit word at byte address a holds the value a.
  logic [10:0] mem_base;
  assign mem_base = {imem_addr, 3'b000};
  always @(posedge clk) begin
    if (imem_req)
      imem_rdata <= {21'd0, mem_base, 21'd0, mem_base + 11'd4};
  end

  typedef struct {
    int base;
    int mask;
    int rdy;
  } pair_t;

  pair_t mq[$];
  int    next_base;
  int    next_mask;
  int    cyc;
  int    n_checks;
  int    n_fail;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    next_base = 0;
    next_mask = 3;
  endtask

  // Entered just after a negedge: drive inputs, check, advance model, move to next negedge.
  task automatic step(input logic fe, input logic rd, input logic [10:0] rpc, input logic ordy);
    logic  exp_valid;
    logic  pop_m;
    logic  exp_req;
    int    occ;
    pair_t p;
    fetch_enable = fe;
    redirect     = rd;
    redirect_pc  = rpc;
    out_ready    = ordy;
    #1;
    exp_valid = (mq.size() > 0) && (mq[0].rdy <= cyc);
    check_eq("out_valid", out_valid, exp_valid);
    if (exp_valid) begin
      check_eq("out_instr1", out_instr1, mq[0].base);
      check_eq("out_instr2", out_instr2, mq[0].base + 4);
      check_eq("out_slot_mask", out_slot_mask, mq[0].mask);
      check_eq("out_pc_plus8", out_pc_plus8, (mq[0].base + 8) % 2048);
    end
    pop_m   = exp_valid && ordy;
    occ     = mq.size() - (pop_m ? 1 : 0);
    exp_req = fe && !rd && (occ < 2);
    check_eq("imem_req", imem_req, exp_req);
    if (exp_req)
      check_eq("imem_addr", imem_addr, next_base / 8);
    if (rd) begin
      mq.delete();
      next_base = int'(rpc) & ~7;
      next_mask = rpc[2] ? 1 : 3;
    end else begin
      if (pop_m) void'(mq.pop_front());
      if (exp_req) begin
        p.base = next_base;
        p.mask = next_mask;
        p.rdy  = cyc + 2;
        mq.push_back(p);
        next_base = (next_base + 8) % 2048;
        next_mask = 3;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    cyc          = 0;
    reset        = 1'b0;
    fetch_enable = 1'b1;
    redirect     = 1'b0;
    redirect_pc  = '0;
    out_ready    = 1'b1;
    model_reset();

    // Reset state with fetch_enable already high.
    @(negedge clk);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_imem_req", imem_req, 1'b0);
    check_eq("rst_instr1", out_instr1, 32'd0);
    check_eq("rst_instr2", out_instr2, 32'd0);
    check_eq("rst_mask", out_slot_mask, 2'b00);
    check_eq("rst_pc_plus8", out_pc_plus8, 11'd0);
    reset = 1'b1;

    // Streaming from address 0.
    repeat (10) step(1'b1, 1'b0, 11'd0, 1'b1);

    // Back-pressure then release.
    repeat (5) step(1'b1, 1'b0, 11'd0, 1'b0);
    repeat (6) step(1'b1, 1'b0, 11'd0, 1'b1);

    // Redirect to 0x104 with the queue holding work and a request in flight.
    step(1'b1, 1'b0, 11'd0, 1'b0);
    step(1'b1, 1'b1, 11'h104, 1'b0);
    repeat (6) step(1'b1, 1'b0, 11'd0, 1'b1);

    // Wrap at the top of memory.
    step(1'b1, 1'b1, 11'd2040, 1'b1);
    repeat (6) step(1'b1, 1'b0, 11'd0, 1'b1);

    // fetch_enable dropped the cycle after a request.
    step(1'b1, 1'b0, 11'd0, 1'b1);
    repeat (6) step(1'b0, 1'b0, 11'd0, 1'b1);

    // Async reset between clock edges while streaming.
    repeat (6) step(1'b1, 1'b0, 11'd0, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check_eq("async_out_valid", out_valid, 1'b0);
    check_eq("async_imem_req", imem_req, 1'b0);
    check_eq("async_mask", out_slot_mask, 2'b00);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_reset();
    repeat (8) step(1'b1, 1'b0, 11'd0, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      step(($urandom % 8) != 0,
           ($urandom % 16) == 0,
           11'($urandom % 2048),
           ($urandom % 4) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
